// File: rtl/pc_vector_unit.sv
// pc_vector_unit: PC register with stall, synchronised irq, trap vectoring.
// Optional misaligned-target trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_vector_unit #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VEC   = WIDTH'(32'h00000000),
   parameter logic [WIDTH-1:0] ILLOP_VEC   = WIDTH'(32'h80000004),
   parameter logic [WIDTH-1:0] XADR_VEC    = WIDTH'(32'h80000008),
   parameter logic [WIDTH-1:0] ALIGN_VEC   = WIDTH'(32'h8000000C),
   parameter int               SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] pc_next,
   input  logic             illop,
   input  logic             irq,
   output logic [WIDTH-1:0] pc_o,
   output logic [WIDTH-1:0] epc_o,
   output logic [2:0]       cause_o,
   output logic             kernel_o,
   output logic             irq_ack_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_d;
   logic                   pending;
   logic                   irq_rise;
   logic                   take_ill;
   logic                   take_irq;
   logic                   take_align;
   logic                   take_seq;
   logic [WIDTH-1:0]       pc_inc;
   logic [WIDTH-1:0]       pc_mask;

   assign kernel_o = pc_o[WIDTH-1];
   assign irq_rise = sync_q[SYNC_STAGES-1] & ~sync_d;
   assign pc_inc   = pc_o + WIDTH'(4);
   // user mode can only reach kernel space through a vector
   assign pc_mask  = {pc_o[WIDTH-1] & pc_next[WIDTH-1],
                      pc_next[WIDTH-2:0]};

   // Synchronise irq and keep one extra flop for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         sync_d <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
         sync_d <= sync_q[SYNC_STAGES-1];
      end
   end

   // Mutually exclusive action selects, highest priority first
   always_comb begin
      take_ill   = en & illop;
      take_irq   = en & ~illop & pending & ~pc_o[WIDTH-1];
`ifdef PC_ALIGN_CHECK_EN
      take_align = en & ~illop & ~take_irq & (pc_next[1:0] != 2'b00);
`else
      take_align = 1'b0;
`endif
      take_seq   = en & ~take_ill & ~take_irq & ~take_align;
   end

   // PC, trap state, pending flag and ack pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_o      <= RESET_VEC;
         epc_o     <= '0;
         cause_o   <= 3'd0;
         irq_ack_o <= 1'b0;
         pending   <= 1'b0;
      end else begin
         irq_ack_o <= take_irq;
         unique case (1'b1)
            take_ill: begin
               pc_o    <= ILLOP_VEC;
               epc_o   <= pc_inc;
               cause_o <= 3'd1;
            end
            take_irq: begin
               pc_o    <= XADR_VEC;
               epc_o   <= pc_next;
               cause_o <= 3'd2;
            end
            take_align: begin
               pc_o    <= ALIGN_VEC;
               epc_o   <= pc_inc;
               cause_o <= 3'd3;
            end
            take_seq: begin
               pc_o    <= pc_mask;
            end
            default: begin
            end
         endcase
         // a fresh edge arriving as the irq is taken stays pending
         if (take_irq)
            pending <= irq_rise;
         else if (irq_rise)
            pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_vector_unit.sv
// tb_pc_vector_unit: directed vectors checked through a scoreboard queue.
// Expected state is tagged with the cycle it must appear in.
module tb_pc_vector_unit;

  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [2:0]  cause;
    logic        ack;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] pc_next;
  logic        illop;
  logic        irq;
  logic [31:0] pc_o;
  logic [31:0] epc_o;
  logic [2:0]  cause_o;
  logic        kernel_o;
  logic        irq_ack_o;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  event chk_ev;

  pc_vector_unit dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .pc_next   (pc_next),
    .illop     (illop),
    .irq       (irq),
    .pc_o      (pc_o),
    .epc_o     (epc_o),
    .cause_o   (cause_o),
    .kernel_o  (kernel_o),
    .irq_ack_o (irq_ack_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk or chk_ev);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_cmp++;
        if (e.cyc != cyc || pc_o !== e.pc ||
            epc_o !== e.epc ||
            cause_o !== e.cause ||
            irq_ack_o !== e.ack ||
            kernel_o !== e.pc[31]) begin
          n_bad++;
          $display("FAIL %s: cyc %0d want %0d",
                   e.name, cyc, e.cyc);
          $display("  pc %h/%h epc %h/%h",
                   pc_o, e.pc, epc_o, e.epc);
          $display("  cause %0d/%0d ack %b/%b kern %b/%b",
                   cause_o, e.cause, irq_ack_o, e.ack,
                   kernel_o, e.pc[31]);
        end
      end
    end
  end

  task automatic push(input string n,
                      input logic [31:0] p,
                      input logic [31:0] ep,
                      input logic [2:0] c,
                      input logic a, input int lag);
    exp_t x;
    x.cyc = cyc + lag;
    x.name = n;
    x.pc = p;
    x.epc = ep;
    x.cause = c;
    x.ack = a;
    q.push_back(x);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string n,
                      input logic e_i, input logic il,
                      input logic [31:0] pn,
                      input logic [31:0] xp,
                      input logic [31:0] xep,
                      input logic [2:0] xc,
                      input logic xa);
    en = e_i;
    illop = il;
    pc_next = pn;
    push(n, xp, xep, xc, xa, 1);
    tick();
  endtask

  task automatic hold3(input string n,
                       input logic [31:0] xp,
                       input logic [31:0] xep,
                       input logic [2:0] xc);
    for (int i = 0; i < 3; i++)
      step(n, 1'b0, 1'b1, 32'h444, xp, xep, xc, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0;
    illop = 1'b0;
    irq = 1'b0;
    pc_next = '0;
    tick();
    push("reset", 32'h0, 32'h0, 3'd0, 1'b0, 0);
    tick();
    reset = 1'b0;

    step("load10", 1, 0, 32'h10, 32'h10, 32'h0, 3'd0, 0);
    step("illop", 1, 1, 32'h999, 32'h80000004,
         32'h14, 3'd1, 0);
    n_cmp++;
    if (pc_o !== 32'h80000004) begin
      n_bad++;
      $display("FAIL d_ill_pc: %h", pc_o);
    end
    n_cmp++;
    if (epc_o !== 32'h14) begin
      n_bad++;
      $display("FAIL d_ill_epc: %h", epc_o);
    end
    n_cmp++;
    if (cause_o !== 3'd1) begin
      n_bad++;
      $display("FAIL d_ill_cause: %0d", cause_o);
    end
    n_cmp++;
    if (kernel_o !== 1'b1) begin
      n_bad++;
      $display("FAIL d_ill_kern: %b", kernel_o);
    end
    step("ret20", 1, 0, 32'h20, 32'h20, 32'h14, 3'd1, 0);

    irq = 1'b1;
    hold3("sync_hold", 32'h20, 32'h14, 3'd1);
    step("irq_take", 1, 0, 32'h24, 32'h80000008,
         32'h24, 3'd2, 1);
    step("irq_ret", 1, 0, 32'h28, 32'h28, 32'h24, 3'd2, 0);
    step("no_retrap", 1, 0, 32'h2C, 32'h2C,
         32'h24, 3'd2, 0);

    irq = 1'b0;
    hold3("irq_low", 32'h2C, 32'h24, 3'd2);
    step("illop2", 1, 1, 32'h0, 32'h80000004,
         32'h30, 3'd1, 0);
    step("kload", 1, 0, 32'h80000100, 32'h80000100,
         32'h30, 3'd1, 0);

    irq = 1'b1;
    hold3("k_sync", 32'h80000100, 32'h30, 3'd1);
    step("kmask", 1, 0, 32'h80000104, 32'h80000104,
         32'h30, 3'd1, 0);
    step("kret", 1, 0, 32'h24, 32'h24, 32'h30, 3'd1, 0);
    step("late_irq", 1, 0, 32'h28, 32'h80000008,
         32'h28, 3'd2, 1);
    step("ack_off", 0, 0, 32'h28, 32'h80000008,
         32'h28, 3'd2, 0);
    step("user30", 1, 0, 32'h30, 32'h30, 32'h28, 3'd2, 0);
    step("mask_up", 1, 0, 32'h80000200, 32'h200,
         32'h28, 3'd2, 0);

    irq = 1'b0;
    hold3("stall", 32'h200, 32'h28, 3'd2);
    irq = 1'b1;
    hold3("stall_sync", 32'h200, 32'h28, 3'd2);
    step("ill_pend", 1, 1, 32'h0, 32'h80000004,
         32'h204, 3'd1, 0);
    step("kret300", 1, 0, 32'h300, 32'h300,
         32'h204, 3'd1, 0);
    step("pend_take", 1, 0, 32'h304, 32'h80000008,
         32'h304, 3'd2, 1);
    step("kwrap", 1, 0, 32'hFFFFFFFC, 32'hFFFFFFFC,
         32'h304, 3'd2, 0);
    step("wrap_ill", 1, 1, 32'h0, 32'h80000004,
         32'h0, 3'd1, 0);
`ifdef PC_ALIGN_CHECK_EN
    step("align", 1, 0, 32'h42, 32'h8000000C,
         32'h80000008, 3'd3, 0);
    step("load40", 1, 0, 32'h40, 32'h40,
         32'h80000008, 3'd3, 0);
`else
    step("align", 1, 0, 32'h42, 32'h42, 32'h0, 3'd1, 0);
    step("load40", 1, 0, 32'h40, 32'h40, 32'h0, 3'd1, 0);
`endif
    en = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (pc_o !== 32'h0) begin
      n_bad++;
      $display("FAIL d_rst_pc: %h", pc_o);
    end
    n_cmp++;
    if (epc_o !== 32'h0) begin
      n_bad++;
      $display("FAIL d_rst_epc: %h", epc_o);
    end
    n_cmp++;
    if (cause_o !== 3'd0) begin
      n_bad++;
      $display("FAIL d_rst_cause: %0d", cause_o);
    end
    n_cmp++;
    if (irq_ack_o !== 1'b0) begin
      n_bad++;
      $display("FAIL d_rst_ack: %b", irq_ack_o);
    end
    n_cmp++;
    if (kernel_o !== 1'b0) begin
      n_bad++;
      $display("FAIL d_rst_kern: %b", kernel_o);
    end
    push("reset_mid", 32'h0, 32'h0, 3'd0, 1'b0, 0);
    -> chk_ev;
    tick();
    irq = 1'b0;
    reset = 1'b0;
    step("post_rst", 1, 0, 32'h8, 32'h8, 32'h0, 3'd0, 0);

    repeat (3) tick();
    while (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never checked, due %0d now %0d",
               e.name, e.cyc, cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
